// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------
// alu_issue_pkg : shared ALU codes, RV32I opcodes, decode types
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

package alu_issue_pkg;

  localparam int ALU_DATA_WIDTH    = 32;
  localparam int ALU_CONTROL_WIDTH = 4;

  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_LT  = 4'b0111;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SLL = 4'b1000;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SRL = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6
  } br_type_t;

  typedef enum logic [1:0] {SRC1_ZERO, SRC1_RS1, SRC1_PC} src1_t;
  typedef enum logic [1:0] {SRC2_ZERO, SRC2_RS2, SRC2_IMM, SRC2_SHAMT} src2_t;

  typedef struct packed {
    logic [ALU_CONTROL_WIDTH-1:0] alu_control;
    src1_t                        src1;
    src2_t                        src2;
    logic                         flip_sign;
    br_type_t                     br;
    logic                         illegal;
  } dec_t;

  // funct3 -> ALU op for the shared R/I-type arithmetic group
  function automatic logic [ALU_CONTROL_WIDTH-1:0] alu_op_of(input logic [2:0] funct3);
    case (funct3)
      3'b001:  alu_op_of = ALU_SLL;
      3'b100:  alu_op_of = ALU_XOR;
      3'b101:  alu_op_of = ALU_SRL;
      3'b110:  alu_op_of = ALU_OR;
      3'b111:  alu_op_of = ALU_AND;
      default: alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_decode.sv
// ---------------------------------------------------------------
// alu_issue_decode : combinational RV32I -> ALU control decoder
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_f3_ok;
  logic       w_is_shift;
  logic       w_unused_fields;

  assign w_opcode        = instr[6:0];
  assign w_funct3        = instr[14:12];
  assign w_funct7        = instr[31:25];
  assign w_f3_ok         = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
  assign w_is_shift      = (w_funct3[1:0] == 2'b01);
  assign w_unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec.alu_control = ALU_ADD;
    dec.src1        = SRC1_ZERO;
    dec.src2        = SRC2_ZERO;
    dec.flip_sign   = 1'b0;
    dec.br          = BR_NONE;
    dec.illegal     = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        if (w_funct7 == 7'b0000000 && w_f3_ok) begin
          dec.alu_control = alu_op_of(w_funct3);
          dec.src1        = SRC1_RS1;
          dec.src2        = SRC2_RS2;
          dec.illegal     = 1'b0;
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          dec.alu_control = ALU_SUB;
          dec.src1        = SRC1_RS1;
          dec.src2        = SRC2_RS2;
          dec.illegal     = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        // SRAI shares funct3 with SRLI and is rejected by the funct7 test
        if (w_f3_ok && (!w_is_shift || w_funct7 == 7'b0000000)) begin
          dec.alu_control = alu_op_of(w_funct3);
          dec.src1        = SRC1_RS1;
          dec.src2        = w_is_shift ? SRC2_SHAMT : SRC2_IMM;
          dec.illegal     = 1'b0;
        end
      end
      OPC_LOAD: begin
        if (w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          dec.src1    = SRC1_RS1;
          dec.src2    = SRC2_IMM;
          dec.illegal = 1'b0;
        end
      end
      OPC_STORE: begin
        if (w_funct3 inside {3'b000, 3'b001, 3'b010}) begin
          dec.src1    = SRC1_RS1;
          dec.src2    = SRC2_IMM;
          dec.illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.src2    = SRC2_IMM;
        dec.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec.src1    = SRC1_PC;
        dec.src2    = SRC2_IMM;
        dec.illegal = 1'b0;
      end
      OPC_BRANCH: begin
        if (w_f3_ok) begin
          dec.src1    = SRC1_RS1;
          dec.src2    = SRC2_RS2;
          dec.illegal = 1'b0;
          case (w_funct3)
            3'b000:  begin dec.alu_control = ALU_SUB; dec.br = BR_EQ;  end
            3'b001:  begin dec.alu_control = ALU_SUB; dec.br = BR_NE;  end
            3'b100:  begin dec.alu_control = ALU_LT;  dec.br = BR_LT;  dec.flip_sign = 1'b1; end
            3'b101:  begin dec.alu_control = ALU_LT;  dec.br = BR_GE;  dec.flip_sign = 1'b1; end
            3'b110:  begin dec.alu_control = ALU_LT;  dec.br = BR_LTU; end
            default: begin dec.alu_control = ALU_LT;  dec.br = BR_GEU; end
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------
// alu_issue : one-entry valid/ready issue register feeding the ALU
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  instr,
  input  logic [DATA_W-1:0]            pc,
  input  logic [DATA_W-1:0]            rs1_data,
  input  logic [DATA_W-1:0]            rs2_data,
  input  logic [DATA_W-1:0]            imm,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ALU_CONTROL_WIDTH-1:0] out_alu_control,
  output logic [DATA_W-1:0]            out_data_1,
  output logic [DATA_W-1:0]            out_data_2,
  output logic                         out_is_branch,
  output logic                         out_illegal,
  input  logic                         alu_zero,
  output logic                         branch_taken
);

  localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};

  dec_t                         w_dec;
  logic [DATA_W-1:0]            w_op1;
  logic [DATA_W-1:0]            w_op2;
  logic                         w_taken;

  logic                         r_valid;
  logic [ALU_CONTROL_WIDTH-1:0] r_ctrl;
  logic [DATA_W-1:0]            r_d1;
  logic [DATA_W-1:0]            r_d2;
  br_type_t                     r_br;
  logic                         r_illegal;

  alu_issue_decode u_decode (
    .instr (instr),
    .dec   (w_dec)
  );

  // Signed compares reuse the unsigned ALU_LT by flipping both sign bits
  always_comb begin
    case (w_dec.src1)
      SRC1_RS1: w_op1 = rs1_data;
      SRC1_PC:  w_op1 = pc;
      default:  w_op1 = '0;
    endcase
    case (w_dec.src2)
      SRC2_RS2:   w_op2 = rs2_data;
      SRC2_IMM:   w_op2 = imm;
      SRC2_SHAMT: w_op2 = {{(DATA_W-5){1'b0}}, imm[4:0]};
      default:    w_op2 = '0;
    endcase
    if (w_dec.flip_sign) begin
      w_op1 = w_op1 ^ SIGN_BIT;
      w_op2 = w_op2 ^ SIGN_BIT;
    end
  end

  assign in_ready = ~rst & (~r_valid | out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_ctrl    <= ALU_AND;
      r_d1      <= '0;
      r_d2      <= '0;
      r_br      <= BR_NONE;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_valid   <= 1'b1;
      r_ctrl    <= w_dec.alu_control;
      r_d1      <= w_op1;
      r_d2      <= w_op2;
      r_br      <= w_dec.br;
      r_illegal <= w_dec.illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // ALU_LT reports "less" as a zero result, hence LT uses alu_zero directly
  always_comb begin
    w_taken = 1'b0;
    case (r_br)
      BR_EQ, BR_LT, BR_LTU: w_taken = alu_zero;
      BR_NE, BR_GE, BR_GEU: w_taken = ~alu_zero;
      default:              w_taken = 1'b0;
    endcase
  end

  assign out_valid       = r_valid;
  assign out_alu_control = r_ctrl;
  assign out_data_1      = r_d1;
  assign out_data_2      = r_d2;
  assign out_is_branch   = (r_br != BR_NONE);
  assign out_illegal     = r_illegal;
  assign branch_taken    = r_valid & out_is_branch & w_taken;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------
// tb_alu_issue : scoreboard bench for alu_issue
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic        out_is_branch, out_illegal, alu_zero, branch_taken;
  logic [31:0] instr, pc, rs1_data, rs2_data, imm, out_data_1, out_data_2;
  logic [ALU_CONTROL_WIDTH-1:0] out_alu_control;

  alu_issue #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_control(out_alu_control), .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_is_branch(out_is_branch), .out_illegal(out_illegal),
    .alu_zero(alu_zero), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    bit          illegal;
    int          kind;  // 0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the ALU should see for each RV32I mnemonic
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im);
    exp_t e;
    int op, f3, f7;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    e.ctrl = ALU_ADD; e.d1 = 0; e.d2 = 0; e.illegal = 1; e.kind = 0;
    case (op)
      'h33: begin
        if (f7 == 0 && f3 != 2 && f3 != 3) begin
          e.illegal = 0; e.d1 = a; e.d2 = b;
          case (f3)
            0: e.ctrl = ALU_ADD; 1: e.ctrl = ALU_SLL; 4: e.ctrl = ALU_XOR;
            5: e.ctrl = ALU_SRL; 6: e.ctrl = ALU_OR;  default: e.ctrl = ALU_AND;
          endcase
        end else if (f7 == 'h20 && f3 == 0) begin
          e.illegal = 0; e.d1 = a; e.d2 = b; e.ctrl = ALU_SUB;
        end
      end
      'h13: begin
        if (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7) begin
          e.illegal = 0; e.d1 = a; e.d2 = im;
          e.ctrl = (f3 == 0) ? ALU_ADD : (f3 == 4) ? ALU_XOR : (f3 == 6) ? ALU_OR : ALU_AND;
        end else if ((f3 == 1 || f3 == 5) && f7 == 0) begin
          e.illegal = 0; e.d1 = a; e.d2 = im % 32;
          e.ctrl = (f3 == 1) ? ALU_SLL : ALU_SRL;
        end
      end
      'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin
              e.illegal = 0; e.d1 = a; e.d2 = im;
            end
      'h23: if (f3 <= 2) begin e.illegal = 0; e.d1 = a; e.d2 = im; end
      'h37: begin e.illegal = 0; e.d2 = im; end
      'h17: begin e.illegal = 0; e.d1 = p; e.d2 = im; end
      'h63: begin
        if (f3 != 2 && f3 != 3) begin
          e.illegal = 0; e.d1 = a; e.d2 = b;
          case (f3)
            0: begin e.kind = 1; e.ctrl = ALU_SUB; end
            1: begin e.kind = 2; e.ctrl = ALU_SUB; end
            4: begin e.kind = 3; e.ctrl = ALU_LT; e.d1 = a + 32'h8000_0000; e.d2 = b + 32'h8000_0000; end
            5: begin e.kind = 4; e.ctrl = ALU_LT; e.d1 = a + 32'h8000_0000; e.d2 = b + 32'h8000_0000; end
            6: begin e.kind = 5; e.ctrl = ALU_LT; end
            default: begin e.kind = 6; e.ctrl = ALU_LT; end
          endcase
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit exp_taken(input int kind, input logic z);
    case (kind)
      1, 3, 5: return z == 1'b1;
      2, 4, 6: return z == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1: r[6:0] = 7'h33;
      2, 3: r[6:0] = 7'h13;
      4:    r[6:0] = 7'h03;
      5:    r[6:0] = 7'h23;
      6:    r[6:0] = 7'h37;
      7:    r[6:0] = 7'h17;
      8:    r[6:0] = 7'h63;
      default: ;
    endcase
    case ($urandom_range(0, 2))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  // One clock of stimulus: inputs already driven; expected handshake derived from bench state
  task automatic cycle();
    bit   held, exp_ready, cap, drop;
    exp_t e;
    held      = (sb.size() != 0);
    exp_ready = !rst && (!held || out_ready);
    cap       = in_valid && exp_ready && !flush;
    drop      = (rst || flush) && held && !out_ready;
    e         = model(instr, pc, rs1_data, rs2_data, imm);
    @(negedge clk);
    check("in_ready", in_ready, exp_ready);
    @(posedge clk);
    if (drop && sb.size() != 0) void'(sb.pop_front());
    if (cap) sb.push_back(e);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin : mon
        exp_t e;
        check("out_valid", out_valid, sb.size() != 0);
        if (out_valid === 1'b1 && sb.size() != 0) begin
          e = sb[0];
          check("alu_control", out_alu_control, e.ctrl);
          check("data_1", out_data_1, e.d1);
          check("data_2", out_data_2, e.d2);
          check("is_branch", out_is_branch, e.kind != 0);
          check("illegal", out_illegal, e.illegal);
          check("branch_taken", branch_taken, exp_taken(e.kind, alu_zero));
          if (out_ready) void'(sb.pop_front());
        end else begin
          check("taken_idle", branch_taken, 32'd0);
        end
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; alu_zero = 0;
    instr = 0; pc = 0; rs1_data = 0; rs2_data = 0; imm = 0;
    @(posedge clk); #1;
    cycle();
    mon_on = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", out_alu_control, ALU_AND);
    check("rst_d1", out_data_1, 0);
    check("rst_d2", out_data_2, 0);
    check("rst_branch", out_is_branch, 0);
    check("rst_illegal", out_illegal, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 0; #1;
    check("post_rst_in_ready", in_ready, 1);

    // ADD x3,x1,x2
    instr = 32'h002081B3; rs1_data = 5; rs2_data = 7; imm = 32'h1234; in_valid = 1; out_ready = 1;
    cycle(); in_valid = 0;
    check("add_valid", out_valid, 1);
    check("add_ctrl", out_alu_control, ALU_ADD);
    check("add_d1", out_data_1, 5);
    check("add_d2", out_data_2, 7);
    check("add_illegal", out_illegal, 0);
    cycle();

    // BLT then BGE with alu_zero=1
    instr = 32'h0020C063; rs1_data = 32'hFFFF_FFFF; rs2_data = 1; in_valid = 1;
    cycle(); in_valid = 0; alu_zero = 1; #1;
    check("blt_d1", out_data_1, 32'h7FFF_FFFF);
    check("blt_d2", out_data_2, 32'h8000_0001);
    check("blt_ctrl", out_alu_control, ALU_LT);
    check("blt_taken", branch_taken, 1);
    instr = 32'h0020D063; in_valid = 1;
    cycle(); in_valid = 0; #1;
    check("bge_taken", branch_taken, 0);
    alu_zero = 0;

    // Stall: AND held while ADDI waits
    instr = 32'h0020F1B3; rs1_data = 32'hF0F0_1111; rs2_data = 32'h0FF0_2222; in_valid = 1; out_ready = 1;
    cycle();
    instr = 32'h12308193; rs1_data = 32'h100; imm = 32'h123; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_in_ready", in_ready, 0);
      check("stall_ctrl", out_alu_control, ALU_AND);
      check("stall_d1", out_data_1, 32'hF0F0_1111);
      check("stall_d2", out_data_2, 32'h0FF0_2222);
    end
    out_ready = 1;
    cycle(); in_valid = 0;
    check("second_ctrl", out_alu_control, ALU_ADD);
    check("second_d1", out_data_1, 32'h100);
    check("second_d2", out_data_2, 32'h123);

    // Flush together with a new instruction
    instr = 32'h002081B3; in_valid = 1; flush = 1;
    cycle(); flush = 0; in_valid = 0;
    check("flush_valid", out_valid, 0);

    // SRA is illegal but still issued
    instr = 32'h4020D1B3; rs1_data = 32'h55; rs2_data = 32'h3; in_valid = 1; alu_zero = 1;
    cycle(); in_valid = 0;
    check("sra_valid", out_valid, 1);
    check("sra_illegal", out_illegal, 1);
    check("sra_ctrl", out_alu_control, ALU_ADD);
    check("sra_d1", out_data_1, 0);
    check("sra_d2", out_data_2, 0);
    check("sra_taken", branch_taken, 0);
    alu_zero = 0;

    // Reset during a stall
    instr = 32'h0020E1B3; in_valid = 1; out_ready = 1;
    cycle(); in_valid = 0; out_ready = 0;
    cycle();
    rst = 1;
    cycle();
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_d1", out_data_1, 0);
    check("rst_stall_d2", out_data_2, 0);
    check("rst_stall_ctrl", out_alu_control, ALU_AND);
    check("rst_stall_illegal", out_illegal, 0);
    check("rst_stall_taken", branch_taken, 0);
    rst = 0; #1;
    check("rst_stall_in_ready", in_ready, 1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      alu_zero  = $urandom_range(0, 1);
      instr     = gen_instr();
      pc        = $urandom;
      rs1_data  = $urandom;
      rs2_data  = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
      imm       = $urandom;
      cycle();
    end

    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
